// File: rtl/regbank_pkg.sv
// regbank_pkg
// Shared definitions for the register-bank processor interface: the
// three-phase round encoding (FETCH/READ/WRITE), the bank command codes
// driven on 'enable', and the phase sequencing helper.
package regbank_pkg;

    // Processor phase. The two-bit encoding leaves value 3 unused; any
    // logic that sees it must fall back to FETCH.
    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_READ  = 2'd1,
        PH_WRITE = 2'd2
    } phase_e;

    // Bank command presented on 'enable'.
    typedef enum logic [2:0] {
        EN_IDLE = 3'd0,
        EN_RD   = 3'd1,
        EN_WR   = 3'd7
    } bank_cmd_e;

    // Phase that follows 'cur'. The unused encoding recovers to FETCH.
    function automatic phase_e next_phase(input phase_e cur);
        phase_e nxt;
        case (cur)
            PH_FETCH: nxt = PH_READ;
            PH_READ:  nxt = PH_WRITE;
            default:  nxt = PH_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/regbank_wr_fifo.sv
// regbank_wr_fifo
// Write-request queue for regbank_driver. Strict first-in first-out,
// power-of-two depth. full/empty are registered, so a pop never changes
// them within the cycle it happens in.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   push, push_data: enqueue request (ignored while full)
//   pop            : dequeue head (ignored while empty)
//   head_data      : current head entry
//   full, empty    : registered occupancy flags
module regbank_wr_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    import regbank_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full_q;
    assign pop_ok_s  = pop && !empty_q;
    assign head_data = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;

    // Next storage, pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Queue state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

endmodule

// File: rtl/regbank_driver.sv
// regbank_driver
// Drives a register bank through a repeating FETCH -> READ -> WRITE round.
// Reads requested in FETCH are issued in READ and their data captured at the
// end of READ; queued writes retire one per round in WRITE.
// Ports:
//   clock, reset_n              : clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_sel/wr_data : write request handshake into the queue
//   rd_req/rd_sel               : read request, sampled only in FETCH
//   rd_data1/rd_data2/rd_done   : captured read data and one-cycle done pulse
//   state                       : current phase
//   enable/sel/dataIn           : registered bank command, select, write data
//   source1/source2             : bank read data
module regbank_driver #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_done,
    output logic [1:0]        state,
    output logic [2:0]        enable,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] source1,
    input  logic [DATA_W-1:0] source2
);
    import regbank_pkg::*;

    localparam int ENTRY_W = DATA_W + SEL_W;

    phase_e            state_q, state_d;
    logic              pend_q, pend_d;
    logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              rd_done_q, rd_done_d;
    bank_cmd_e         enable_q, enable_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              wr_active_q, wr_active_d;

    logic               fifo_push_s;
    logic               fifo_pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [ENTRY_W-1:0] fifo_head_s;
    logic [SEL_W-1:0]   head_sel_s;
    logic [DATA_W-1:0]  head_data_s;

    assign wr_ready    = !fifo_full_s;
    assign fifo_push_s = wr_valid && !fifo_full_s;
    // Only the entry presented during this WRITE phase retires.
    assign fifo_pop_s  = (state_q == PH_WRITE) && wr_active_q;
    assign head_sel_s  = fifo_head_s[ENTRY_W-1 -: SEL_W];
    assign head_data_s = fifo_head_s[DATA_W-1:0];

    regbank_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push_s),
        .push_data ({wr_sel, wr_data}),
        .pop       (fifo_pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Phase sequencing, read bookkeeping and the bank command for the next phase.
    always_comb begin
        state_d     = next_phase(state_q);
        pend_d      = pend_q;
        rd_sel_d    = rd_sel_q;
        rd_data1_d  = rd_data1_q;
        rd_data2_d  = rd_data2_q;
        rd_done_d   = 1'b0;
        enable_d    = EN_IDLE;
        sel_d       = sel_q;
        data_in_d   = data_in_q;
        wr_active_d = 1'b0;

        case (state_q)
            PH_FETCH: begin
                if (rd_req) begin
                    pend_d   = 1'b1;
                    rd_sel_d = rd_sel;
                end else begin
                    pend_d = pend_q;
                end
            end
            PH_READ: begin
                // The bank has been addressed for the whole READ phase.
                if (pend_q) begin
                    rd_data1_d = source1;
                    rd_data2_d = source2;
                    rd_done_d  = 1'b1;
                    pend_d     = 1'b0;
                end else begin
                    rd_done_d = 1'b0;
                end
            end
            default: begin
                rd_done_d = 1'b0;
            end
        endcase

        // Decode on the phase being entered so the command is stable for all of it.
        // The write decision uses pre-edge emptiness, so a push landing on this
        // edge waits for the following round.
        case (state_d)
            PH_READ: begin
                if (pend_d) begin
                    enable_d = EN_RD;
                    sel_d    = rd_sel_d;
                end else begin
                    enable_d = EN_IDLE;
                end
            end
            PH_WRITE: begin
                if (!fifo_empty_s) begin
                    enable_d    = EN_WR;
                    sel_d       = head_sel_s;
                    data_in_d   = head_data_s;
                    wr_active_d = 1'b1;
                end else begin
                    enable_d = EN_IDLE;
                end
            end
            default: begin
                enable_d = EN_IDLE;
            end
        endcase
    end

    // Phase, read-capture and bank-command registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PH_FETCH;
            pend_q      <= 1'b0;
            rd_sel_q    <= {SEL_W{1'b0}};
            rd_data1_q  <= {DATA_W{1'b0}};
            rd_data2_q  <= {DATA_W{1'b0}};
            rd_done_q   <= 1'b0;
            enable_q    <= EN_IDLE;
            sel_q       <= {SEL_W{1'b0}};
            data_in_q   <= {DATA_W{1'b0}};
            wr_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            rd_sel_q    <= rd_sel_d;
            rd_data1_q  <= rd_data1_d;
            rd_data2_q  <= rd_data2_d;
            rd_done_q   <= rd_done_d;
            enable_q    <= enable_d;
            sel_q       <= sel_d;
            data_in_q   <= data_in_d;
            wr_active_q <= wr_active_d;
        end
    end

    assign state    = state_q;
    assign enable   = enable_q;
    assign sel      = sel_q;
    assign dataIn   = data_in_q;
    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_done  = rd_done_q;

endmodule
